// File: rtl/display_mux_if.sv
// rtl/display_mux_if.sv - front-panel display value inputs and scanned digit/segment outputs
interface display_mux_if;
    logic [15:0] disp_addr;
    logic [7:0]  disp_data;
    logic [5:0]  disp_dp;
    logic        disp_update;
    logic        disp_blank;
    logic [5:0]  DISP_digit;
    logic [7:0]  DISP_seg;
    logic        frame_tick;

    modport master (
        output disp_addr, disp_data, disp_dp, disp_update, disp_blank,
        input  DISP_digit, DISP_seg, frame_tick
    );

    modport slave (
        input  disp_addr, disp_data, disp_dp, disp_update, disp_blank,
        output DISP_digit, DISP_seg, frame_tick
    );
endinterface

// File: rtl/display_mux.sv
// rtl/display_mux.sv - six-digit multiplexed 7-segment driver with frame-synchronous double buffer
module display_mux #(
    parameter int SLOT_BITS   = 15,
    parameter int GUARD_TICKS = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    display_mux_if.slave bus
);
    localparam logic [SLOT_BITS-1:0] GUARD      = SLOT_BITS'(GUARD_TICKS);
    localparam logic [SLOT_BITS-1:0] SLOT_LAST  = '1;
    localparam logic [2:0]           LAST_DIGIT = 3'd5;

    logic [SLOT_BITS-1:0] slot_cnt;
    logic [2:0]           idx;
    logic                 tc;
    logic                 frame;

    logic [15:0] pend_addr, act_addr;
    logic [7:0]  pend_data, act_data;
    logic [5:0]  pend_dp, act_dp;
    logic        pend_valid;

    logic [5:0]  digit;
    logic [7:0]  seg;
    logic [3:0]  nib;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign tc    = (slot_cnt == SLOT_LAST);
    assign frame = tc && (idx == LAST_DIGIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            idx      <= '0;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
            if (tc) begin
                idx <= (idx == LAST_DIGIT) ? 3'd0 : idx + 3'd1;
            end
        end
    end

    // A strobe on the boundary cycle still lets the older pending value load; the new one waits a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_addr  <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
            act_addr   <= '0;
            act_data   <= '0;
            act_dp     <= '0;
        end else begin
            if (frame && pend_valid) begin
                act_addr   <= pend_addr;
                act_data   <= pend_data;
                act_dp     <= pend_dp;
                pend_valid <= 1'b0;
            end
            if (bus.disp_update) begin
                pend_addr  <= bus.disp_addr;
                pend_data  <= bus.disp_data;
                pend_dp    <= bus.disp_dp;
                pend_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        nib = act_addr[15:12];
        case (idx)
            3'd1:    nib = act_addr[11:8];
            3'd2:    nib = act_addr[7:4];
            3'd3:    nib = act_addr[3:0];
            3'd4:    nib = act_data[7:4];
            3'd5:    nib = act_data[3:0];
            default: nib = act_addr[15:12];
        endcase
    end

    // Segments latch once per slot so they are settled before the guard interval ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg   <= '0;
            digit <= '0;
        end else begin
            if (slot_cnt == '0) begin
                seg <= {act_dp[idx], hex7(nib)};
            end
            if ((slot_cnt >= GUARD) && !bus.disp_blank) begin
                digit <= 6'd1 << idx;
            end else begin
                digit <= '0;
            end
        end
    end

    assign bus.DISP_digit = digit;
    assign bus.DISP_seg   = seg;
    assign bus.frame_tick = frame;
endmodule

// File: tb/tb_display_mux.sv
// tb/tb_display_mux.sv - self-checking bench for display_mux with a per-digit expectation queue
module tb_display_mux;
    localparam int SLOT  = 16;
    localparam int FRAME = 96;

    typedef struct packed {
        logic [5:0] digit;
        logic [7:0] seg;
    } exp_t;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic [5:0]  dp;
        logic        decoy;
        logic [47:0] segs;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   tb_cyc;
    logic [5:0] prev_digit;
    exp_t q[$];
    vec_t vecs[4];
    logic [47:0] cur;

    display_mux_if bus ();

    display_mux #(.SLOT_BITS(4), .GUARD_TICKS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= 0;
        else        tb_cyc <= tb_cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [47:0] segs, input logic [5:0] mask);
        for (int k = 0; k < 6; k++) begin
            if (mask[k]) q.push_back('{digit: 6'd1 << k, seg: segs[47-8*k -: 8]});
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frame_end();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.frame_tick !== 1'b1 && n < 200);
        check("frame_tick_seen", {31'd0, bus.frame_tick}, 32'd1);
        check("queue_drained_at_frame", q.size(), 0);
    endtask

    task automatic strobe(input logic [15:0] a, input logic [7:0] d, input logic [5:0] p);
        bus.disp_addr   = a;
        bus.disp_data   = d;
        bus.disp_dp     = p;
        bus.disp_update = 1'b1;
        @(negedge clk);
        bus.disp_update = 1'b0;
    endtask

    // Monitor: every lit-period start must match the head of the queue; invariants every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            check("onehot0", {31'd0, $onehot0(bus.DISP_digit)}, 32'd1);
            if ((tb_cyc % SLOT) == 1 || (tb_cyc % SLOT) == 2)
                check("guard_dark", {26'd0, bus.DISP_digit}, 32'd0);
            check("frame_tick_timing", {31'd0, bus.frame_tick},
                  {31'd0, (tb_cyc % FRAME) == FRAME - 1});
            if (bus.DISP_digit != 6'd0 && prev_digit == 6'd0) begin
                if (q.size() == 0) begin
                    check("unexpected_digit", {26'd0, bus.DISP_digit}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("digit_select", {26'd0, bus.DISP_digit}, {26'd0, e.digit});
                    check("segments", {24'd0, bus.DISP_seg}, {24'd0, e.seg});
                end
            end
        end
        prev_digit = bus.DISP_digit;
    end

    initial begin
        vecs[0] = '{16'h1234, 8'hAB, 6'b100000, 1'b0, 48'h06_5B_4F_66_77_FC};
        vecs[1] = '{16'hBEEF, 8'hCD, 6'b000000, 1'b1, 48'h7C_79_79_71_39_5E};
        vecs[2] = '{16'h5678, 8'h90, 6'b010101, 1'b0, 48'hED_7D_87_7F_EF_3F};
        vecs[3] = '{16'h0000, 8'hEF, 6'b111111, 1'b0, 48'hBF_BF_BF_BF_F9_F1};

        bus.disp_addr   = '0;
        bus.disp_data   = '0;
        bus.disp_dp     = '0;
        bus.disp_update = 1'b0;
        bus.disp_blank  = 1'b0;
        prev_digit      = '0;

        wait_cycles(3);
        check("reset_digit", {26'd0, bus.DISP_digit}, 32'd0);
        check("reset_seg", {24'd0, bus.DISP_seg}, 32'd0);
        check("reset_frame_tick", {31'd0, bus.frame_tick}, 32'd0);
        rst_n = 1'b1;
        cur = {6{8'h3F}};
        push_frame(cur, 6'h3F);

        // Table-driven frames: old value visible until the boundary, new value for the next frame.
        for (int i = 0; i < 4; i++) begin
            wait_cycles(30);
            if (vecs[i].decoy) strobe(16'h1111, vecs[i].data, vecs[i].dp);
            wait_cycles(5);
            strobe(vecs[i].addr, vecs[i].data, vecs[i].dp);
            wait_frame_end();
            cur = vecs[i].segs;
            push_frame(cur, 6'h3F);
        end

        // Strobe coincident with the boundary: earlier pending loads now, strobed value one frame later.
        wait_cycles(30);
        strobe(16'hC0DE, 8'h42, 6'b000000);
        wait_frame_end();
        push_frame(cur, 6'h00);
        push_frame(48'h39_3F_5E_79_66_5B, 6'h3F);
        strobe(16'hF00D, 8'h17, 6'b000000);
        wait_frame_end();
        cur = 48'h71_3F_3F_5E_06_07;
        push_frame(cur, 6'h3F);
        wait_frame_end();

        // Blank for 40 cycles covering slots 0 and 1; digit 2 lights once released.
        push_frame(cur, 6'b111100);
        wait_cycles(2);
        bus.disp_blank = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("blank_dark", {26'd0, bus.DISP_digit}, 32'd0);
        end
        bus.disp_blank = 1'b0;
        wait_frame_end();

        // Asynchronous reset while digit 3 is lit.
        push_frame(cur, 6'h3F);
        wait_cycles(56);
        check("pre_reset_digit3", {26'd0, bus.DISP_digit}, 32'h08);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_digit", {26'd0, bus.DISP_digit}, 32'd0);
        check("async_reset_seg", {24'd0, bus.DISP_seg}, 32'd0);
        check("async_reset_frame_tick", {31'd0, bus.frame_tick}, 32'd0);
        q.delete();
        wait_cycles(2);
        rst_n = 1'b1;
        cur = {6{8'h3F}};
        push_frame(cur, 6'h3F);
        wait_frame_end();
        push_frame(cur, 6'h3F);
        wait_frame_end();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
